// File: rtl/cache_control_nway.sv
// Control FSM for an N-way set-associative write-back cache: hit/miss handling, victim choice, pmem handshake.
// Hits complete in the request cycle; misses hold pmem_read/pmem_write until pmem_resp, with saturating event counters.
module cache_control_nway #(
  parameter int WAYS           = 4,
  parameter int WAY_BITS       = $clog2(WAYS),
  parameter bit WRITE_ALLOCATE = 1'b1,
  parameter int CNT_W          = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic                mem_resp,
  input  logic [WAYS-1:0]     hit_vec,
  input  logic [WAYS-1:0]     valid_vec,
  input  logic [WAYS-1:0]     dirty_vec,
  input  logic [WAY_BITS-1:0] lru_way,
  output logic [WAY_BITS-1:0] way_sel,
  output logic [WAYS-1:0]     data_write,
  output logic [WAYS-1:0]     dirty_write,
  output logic                dirty_val,
  output logic                inw,
  output logic                lru_update,
  output logic [WAY_BITS-1:0] lru_used,
  output logic                wb_addr_sel,
  output logic                pmem_read,
  output logic                pmem_write,
  input  logic                pmem_resp,
  input  logic                clr_counts,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count,
  output logic [CNT_W-1:0]    wb_count
);

  typedef enum logic [2:0] {CHECK, WRITEBACK, FILL, RESPOND, WTHRU} state_t;

  state_t              state, state_nxt;
  logic [WAY_BITS-1:0] victim_q, victim_nxt, hw, free_way;
  logic [WAYS-1:0]     hw_oh, victim_oh;
  logic                req, any_hit, any_free;
  logic                hit_ev, miss_ev, wb_ev;

  assign req       = mem_read | mem_write;
  assign any_hit   = |hit_vec;
  assign any_free  = ~&valid_vec;
  assign hw_oh     = {{(WAYS-1){1'b0}}, 1'b1} << hw;
  assign victim_oh = {{(WAYS-1){1'b0}}, 1'b1} << victim_q;

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    hw       = '0;
    free_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i])    hw       = WAY_BITS'(i);
      if (!valid_vec[i]) free_way = WAY_BITS'(i);
    end
    victim_nxt = any_free ? free_way : lru_way;
  end

  always_comb begin
    state_nxt   = state;
    mem_resp    = 1'b0;
    way_sel     = '0;
    data_write  = '0;
    dirty_write = '0;
    dirty_val   = 1'b0;
    inw         = 1'b0;
    lru_update  = 1'b0;
    lru_used    = '0;
    wb_addr_sel = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    hit_ev      = 1'b0;
    miss_ev     = 1'b0;
    wb_ev       = 1'b0;
    case (state)
      CHECK: begin
        if (req && any_hit) begin
          mem_resp   = 1'b1;
          lru_update = 1'b1;
          lru_used   = hw;
          way_sel    = hw;
          hit_ev     = 1'b1;
          if (mem_write) begin
            data_write  = hw_oh;
            inw         = 1'b1;
            dirty_write = hw_oh;
            dirty_val   = 1'b1;
          end
        end else if (req) begin
          miss_ev = 1'b1;
          if (mem_write && !WRITE_ALLOCATE)
            state_nxt = WTHRU;
          else if (valid_vec[victim_nxt] && dirty_vec[victim_nxt])
            state_nxt = WRITEBACK;
          else
            state_nxt = FILL;
        end
      end
      WRITEBACK: begin
        pmem_write  = 1'b1;
        wb_addr_sel = 1'b1;
        way_sel     = victim_q;
        if (pmem_resp) begin
          dirty_write = victim_oh;
          wb_ev       = 1'b1;
          state_nxt   = FILL;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        way_sel   = victim_q;
        if (pmem_resp) begin
          data_write = victim_oh;
          state_nxt  = RESPOND;
        end
      end
      RESPOND: begin
        mem_resp   = 1'b1;
        lru_update = 1'b1;
        lru_used   = victim_q;
        way_sel    = victim_q;
        if (mem_write) begin
          data_write  = victim_oh;
          inw         = 1'b1;
          dirty_write = victim_oh;
          dirty_val   = 1'b1;
        end
        state_nxt = CHECK;
      end
      WTHRU: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          mem_resp  = 1'b1;
          state_nxt = CHECK;
        end
      end
      default: state_nxt = CHECK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CHECK;
      victim_q <= '0;
    end else begin
      state <= state_nxt;
      if (miss_ev) victim_q <= victim_nxt;
    end
  end

  // Counters stick at all-ones; a clear beats any same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else if (clr_counts) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (hit_ev && !(&hit_count))   hit_count  <= hit_count + CNT_W'(1);
      if (miss_ev && !(&miss_count)) miss_count <= miss_count + CNT_W'(1);
      if (wb_ev && !(&wb_count))     wb_count   <= wb_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cache_control_nway.sv
// Bench for cache_control_nway: a write-allocate instance (0) and a no-write-allocate instance (1), both 4-way with 4-bit counters.
module tb_cache_control_nway;

  logic       clk;
  logic       rst_n;
  logic       mem_read[2], mem_write[2], pmem_resp[2], clr_counts[2];
  logic [3:0] hit_vec[2], valid_vec[2], dirty_vec[2];
  logic [1:0] lru_way[2];
  logic       mem_resp[2], dirty_val[2], inw[2], lru_update[2];
  logic       wb_addr_sel[2], pmem_read[2], pmem_write[2];
  logic [1:0] way_sel[2], lru_used[2];
  logic [3:0] data_write[2], dirty_write[2];
  logic [3:0] hit_count[2], miss_count[2], wb_count[2];

  int n_cmp = 0;
  int n_err = 0;
  int e_hit[2], e_miss[2], e_wb[2];

  cache_control_nway #(.WAYS(4), .WRITE_ALLOCATE(1'b1), .CNT_W(4)) u_alloc (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_resp(mem_resp[0]),
    .hit_vec(hit_vec[0]), .valid_vec(valid_vec[0]), .dirty_vec(dirty_vec[0]), .lru_way(lru_way[0]),
    .way_sel(way_sel[0]), .data_write(data_write[0]), .dirty_write(dirty_write[0]), .dirty_val(dirty_val[0]),
    .inw(inw[0]), .lru_update(lru_update[0]), .lru_used(lru_used[0]), .wb_addr_sel(wb_addr_sel[0]),
    .pmem_read(pmem_read[0]), .pmem_write(pmem_write[0]), .pmem_resp(pmem_resp[0]), .clr_counts(clr_counts[0]),
    .hit_count(hit_count[0]), .miss_count(miss_count[0]), .wb_count(wb_count[0]));

  cache_control_nway #(.WAYS(4), .WRITE_ALLOCATE(1'b0), .CNT_W(4)) u_noalloc (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_resp(mem_resp[1]),
    .hit_vec(hit_vec[1]), .valid_vec(valid_vec[1]), .dirty_vec(dirty_vec[1]), .lru_way(lru_way[1]),
    .way_sel(way_sel[1]), .data_write(data_write[1]), .dirty_write(dirty_write[1]), .dirty_val(dirty_val[1]),
    .inw(inw[1]), .lru_update(lru_update[1]), .lru_used(lru_used[1]), .wb_addr_sel(wb_addr_sel[1]),
    .pmem_read(pmem_read[1]), .pmem_write(pmem_write[1]), .pmem_resp(pmem_resp[1]), .clr_counts(clr_counts[1]),
    .hit_count(hit_count[1]), .miss_count(miss_count[1]), .wb_count(wb_count[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Isolate the lowest set bit arithmetically, then take its index.
  function automatic int lowest(input logic [3:0] x);
    int xi;
    xi = int'(x);
    return $clog2(xi & -xi);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input int d, input string tag, input logic resp, input logic [1:0] ws,
                         input logic [3:0] dw, input logic [3:0] dirw, input logic dv, input logic iw,
                         input logic lu, input logic [1:0] lused, input logic wbs, input logic pr, input logic pw);
    chk({tag, ".mem_resp"},    32'(mem_resp[d]),    32'(resp));
    chk({tag, ".way_sel"},     32'(way_sel[d]),     32'(ws));
    chk({tag, ".data_write"},  32'(data_write[d]),  32'(dw));
    chk({tag, ".dirty_write"}, 32'(dirty_write[d]), 32'(dirw));
    chk({tag, ".dirty_val"},   32'(dirty_val[d]),   32'(dv));
    chk({tag, ".inw"},         32'(inw[d]),         32'(iw));
    chk({tag, ".lru_update"},  32'(lru_update[d]),  32'(lu));
    chk({tag, ".lru_used"},    32'(lru_used[d]),    32'(lused));
    chk({tag, ".wb_addr_sel"}, 32'(wb_addr_sel[d]), 32'(wbs));
    chk({tag, ".pmem_read"},   32'(pmem_read[d]),   32'(pr));
    chk({tag, ".pmem_write"},  32'(pmem_write[d]),  32'(pw));
  endtask

  task automatic chk_cnt(input int d, input string tag);
    chk({tag, ".hit_count"},  32'(hit_count[d]),  32'(e_hit[d]));
    chk({tag, ".miss_count"}, 32'(miss_count[d]), 32'(e_miss[d]));
    chk({tag, ".wb_count"},   32'(wb_count[d]),   32'(e_wb[d]));
  endtask

  task automatic clear_model(input int d);
    e_hit[d] = 0; e_miss[d] = 0; e_wb[d] = 0;
  endtask

  task automatic idle(input int d, input bit clr);
    mem_read[d] = 1'b0; mem_write[d] = 1'b0; clr_counts[d] = clr;
    hit_vec[d] = 4'($urandom_range(0, 15));
    @(negedge clk);
    chk_out(d, "idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    if (clr) clear_model(d);
    clr_counts[d] = 1'b0;
    chk_cnt(d, "idle");
  endtask

  // One CPU request, held until completion; entered and left at posedge+1.
  task automatic do_req(input int d, input bit wr, input bit rd_too, input logic [3:0] hv,
                        input logic [3:0] vv, input logic [3:0] dv, input logic [1:0] lw,
                        input int wlat, input int flat, input bit clr);
    int hw, v;
    logic [3:0] oh;
    mem_write[d] = wr; mem_read[d] = !wr || rd_too;
    hit_vec[d] = hv; valid_vec[d] = vv; dirty_vec[d] = dv; lru_way[d] = lw;
    clr_counts[d] = clr;
    if (hv != 4'b0) begin
      hw = lowest(hv);
      oh = 4'b0001 << hw;
      @(negedge clk);
      chk_out(d, "hit", 1, 2'(hw), wr ? oh : 4'b0, wr ? oh : 4'b0, wr, wr, 1, 2'(hw), 0, 0, 0);
      @(posedge clk); #1;
      if (clr) clear_model(d); else e_hit[d] = sat(e_hit[d] + 1);
      clr_counts[d] = 1'b0;
      chk_cnt(d, "hit");
    end else begin
      v  = (vv != 4'hf) ? lowest(~vv) : int'(lw);
      oh = 4'b0001 << v;
      @(negedge clk);
      chk_out(d, "miss_check", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      if (clr) clear_model(d); else e_miss[d] = sat(e_miss[d] + 1);
      clr_counts[d] = 1'b0;
      chk_cnt(d, "miss_check");
      if (wr && d == 1) begin
        for (int k = 0; k < wlat; k++) begin
          pmem_resp[d] = (k == wlat - 1);
          @(negedge clk);
          chk_out(d, "wthru", k == wlat - 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
          @(posedge clk); #1;
        end
        pmem_resp[d] = 1'b0;
      end else begin
        if (vv[v] && dv[v]) begin
          for (int k = 0; k < wlat; k++) begin
            pmem_resp[d] = (k == wlat - 1);
            @(negedge clk);
            chk_out(d, "wb", 0, 2'(v), 0, (k == wlat - 1) ? oh : 4'b0, 0, 0, 0, 0, 1, 0, 1);
            @(posedge clk); #1;
          end
          pmem_resp[d] = 1'b0;
          e_wb[d] = sat(e_wb[d] + 1);
          chk_cnt(d, "wb");
        end
        for (int k = 0; k < flat; k++) begin
          pmem_resp[d] = (k == flat - 1);
          @(negedge clk);
          chk_out(d, "fill", 0, 2'(v), (k == flat - 1) ? oh : 4'b0, 0, 0, 0, 0, 0, 0, 1, 0);
          @(posedge clk); #1;
        end
        pmem_resp[d] = 1'b0;
        @(negedge clk);
        chk_out(d, "respond", 1, 2'(v), wr ? oh : 4'b0, wr ? oh : 4'b0, wr, wr, 1, 2'(v), 0, 0, 0);
        @(posedge clk); #1;
        chk_cnt(d, "respond");
      end
    end
    mem_read[d] = 1'b0; mem_write[d] = 1'b0;
  endtask

  initial begin
    int d;
    bit wr;
    logic [3:0] hv;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_read[i] = 1'b0; mem_write[i] = 1'b0; pmem_resp[i] = 1'b0; clr_counts[i] = 1'b0;
      hit_vec[i] = 4'b0; valid_vec[i] = 4'b0; dirty_vec[i] = 4'b0; lru_way[i] = 2'b0;
      clear_model(i);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk_out(i, "reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk_cnt(i, "reset");
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_req(0, 0, 0, 4'b0100, 4'hf, 4'h0, 2'd0, 1, 1, 0);
    do_req(0, 1, 0, 4'b1000, 4'hf, 4'h0, 2'd0, 1, 1, 0);
    do_req(0, 0, 0, 4'b0000, 4'b1011, 4'h0, 2'd0, 1, 6, 0);
    do_req(0, 0, 0, 4'b0000, 4'b1111, 4'b0010, 2'd1, 3, 2, 0);
    do_req(1, 1, 0, 4'b0000, 4'b1111, 4'b1111, 2'd2, 4, 1, 0);
    do_req(1, 0, 0, 4'b0000, 4'b1111, 4'b0100, 2'd2, 2, 3, 0);
    do_req(0, 1, 1, 4'b0110, 4'hf, 4'h0, 2'd0, 1, 1, 0);

    idle(0, 1'b1);
    for (int i = 0; i < 20; i++)
      do_req(0, 1'($urandom_range(0, 1)), 0, 4'($urandom_range(1, 15)), 4'hf, 4'h0, 2'd0, 1, 1, 0);
    chk("sat.hit_count", 32'(hit_count[0]), 32'd15);
    do_req(0, 0, 0, 4'b0001, 4'hf, 4'h0, 2'd0, 1, 1, 1);
    chk("clr_hit.hit_count", 32'(hit_count[0]), 32'd0);

    // Reset while a fill is outstanding
    mem_read[0] = 1'b1; hit_vec[0] = 4'b0; valid_vec[0] = 4'b0111; dirty_vec[0] = 4'b0;
    @(posedge clk); #1;
    e_miss[0] = sat(e_miss[0] + 1);
    @(negedge clk);
    chk("rstfill.pre_pmem_read", 32'(pmem_read[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstfill.pmem_read", 32'(pmem_read[0]), 32'd0);
    chk("rstfill.pmem_write", 32'(pmem_write[0]), 32'd0);
    clear_model(0); clear_model(1);
    chk_cnt(0, "rstfill");
    chk_cnt(1, "rstfill");
    mem_read[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_req(0, 0, 0, 4'b0010, 4'hf, 4'h0, 2'd0, 1, 1, 0);

    // Randomised traffic on both instances
    for (int n = 0; n < 160; n++) begin
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      hv = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0;
      if ($urandom_range(0, 9) == 0)
        idle(d, 1'($urandom_range(0, 1)));
      else
        do_req(d, wr, wr && ($urandom_range(0, 3) == 0), hv, 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
               int'($urandom_range(1, 4)), ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
